// File: rtl/fetch_pc_gen_pkg.sv
// rtl/fetch_pc_gen_pkg.sv - counter encodings, queue entry type and taken decode for fetch_pc_gen
package fetch_pc_gen_pkg;

  localparam logic [1:0] PRED_ST = 2'b00;
  localparam logic [1:0] PRED_WT = 2'b01;
  localparam logic [1:0] PRED_SN = 2'b10;
  localparam logic [1:0] PRED_WN = 2'b11;

  localparam int ENTRY_W = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } predEntry_t;

  // A zero BTB target means "no entry", which can never be predicted taken.
  function automatic logic predTaken(input logic [1:0] cnt, input logic [31:0] target);
    logic dirTaken;
    case (cnt)
      PRED_ST, PRED_WT: dirTaken = 1'b1;
      PRED_SN, PRED_WN: dirTaken = 1'b0;
      default:          dirTaken = 1'b0;
    endcase
    return dirTaken && (target != 32'd0);
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// rtl/pred_fifo.sv - in-flight prediction queue, wrap-around pointers with an occupancy count
module pred_fifo
  import fetch_pc_gen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  predEntry_t pushEntry,
  output logic       full,
  output logic       empty,
  output predEntry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  predEntry_t  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= pushEntry;
    end
  end

  // Flush wins over everything; the top never pushes in a flush cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW + 1)'(1);
      end
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

endmodule

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator: BTB lookup, in-flight prediction queue, resolve compare and BTB update
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] btbPc,
  input  logic [31:0] btaBuffOp,
  input  logic [1:0]  predBuffOp,
  output logic [31:0] fetchPc,
  output logic        fetchValid,
  input  logic        resolveValid,
  output logic        resolveReady,
  input  logic        resolveTaken,
  input  logic [31:0] resolveTarget,
  output logic        redirect,
  output logic        btaWrite,
  output logic [31:0] bta,
  output logic        actualPredict,
  output logic        writePredBuffEn,
  output logic        resolveErr
);

  logic [31:0] pcQ;
  logic        updActive;
  logic        updTaken;
  logic [31:0] updPc;
  logic [31:0] updTarget;
  logic        errQ;

  logic        full;
  logic        empty;
  predEntry_t  head;
  predEntry_t  pushEntry;

  logic        predTakenNow;
  logic [31:0] predNext;
  logic        resolveFire;
  logic        mispredict;
  logic        fetchFire;

  always_comb begin
    predTakenNow = predTaken(predBuffOp, btaBuffOp);
    predNext     = predTakenNow ? btaBuffOp : pcQ + 32'd1;
    resolveFire  = resolveValid && !empty && !updActive;
    mispredict   = resolveFire &&
                   ((head.taken != resolveTaken) ||
                    (resolveTaken && (head.target != resolveTarget)));
    fetchFire    = !stall && !full && !updActive && !mispredict;
    pushEntry    = '{pc: pcQ, taken: predTakenNow, target: btaBuffOp};
  end

  pred_fifo #(
    .DEPTH(DEPTH)
  ) u_pred_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fetchFire),
    .pop      (resolveFire),
    .flush    (mispredict),
    .pushEntry(pushEntry),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  // The update stage borrows the BTB port for one whole cycle, which also
  // blocks fetch so the corrected PC is first fetched the cycle after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcQ       <= RESET_PC;
      updActive <= 1'b0;
      updTaken  <= 1'b0;
      updPc     <= '0;
      updTarget <= '0;
      errQ      <= 1'b0;
    end else begin
      if (mispredict) begin
        pcQ <= resolveTaken ? resolveTarget : head.pc + 32'd1;
      end else if (fetchFire) begin
        pcQ <= predNext;
      end
      updActive <= resolveFire;
      if (resolveFire) begin
        updPc     <= head.pc;
        updTaken  <= resolveTaken;
        updTarget <= resolveTarget;
      end
      if (resolveValid && empty) begin
        errQ <= 1'b1;
      end
    end
  end

  assign fetchPc         = pcQ;
  assign btbPc           = updActive ? updPc : pcQ;
  assign fetchValid      = fetchFire && reset;
  assign resolveReady    = !empty && !updActive;
  assign redirect        = mispredict;
  assign writePredBuffEn = updActive;
  assign actualPredict   = updActive && updTaken;
  assign btaWrite        = updActive && updTaken;
  assign bta             = updActive ? updTarget : 32'd0;
  assign resolveErr      = errQ;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb/tb_fetch_pc_gen.sv - directed self-checking bench for fetch_pc_gen
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] btbPc;
  logic [31:0] btaBuffOp;
  logic [1:0]  predBuffOp;
  logic [31:0] fetchPc;
  logic        fetchValid;
  logic        resolveValid;
  logic        resolveReady;
  logic        resolveTaken;
  logic [31:0] resolveTarget;
  logic        redirect;
  logic        btaWrite;
  logic [31:0] bta;
  logic        actualPredict;
  logic        writePredBuffEn;
  logic        resolveErr;

  logic [31:0] btbTgt [4];
  logic [1:0]  btbCnt [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign btaBuffOp  = btbTgt[btbPc[1:0]];
  assign predBuffOp = btbCnt[btbPc[1:0]];

  fetch_pc_gen #(
    .RESET_PC(32'd0),
    .DEPTH   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .btbPc          (btbPc),
    .btaBuffOp      (btaBuffOp),
    .predBuffOp     (predBuffOp),
    .fetchPc        (fetchPc),
    .fetchValid     (fetchValid),
    .resolveValid   (resolveValid),
    .resolveReady   (resolveReady),
    .resolveTaken   (resolveTaken),
    .resolveTarget  (resolveTarget),
    .redirect       (redirect),
    .btaWrite       (btaWrite),
    .bta            (bta),
    .actualPredict  (actualPredict),
    .writePredBuffEn(writePredBuffEn),
    .resolveErr     (resolveErr)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clearBtb();
    for (int i = 0; i < 4; i++) begin
      btbTgt[i] = 32'd0;
      btbCnt[i] = 2'b10;
    end
  endtask

  task automatic doReset();
    reset         = 1'b0;
    stall         = 1'b0;
    resolveValid  = 1'b0;
    resolveTaken  = 1'b0;
    resolveTarget = 32'd0;
    tick();
    reset = 1'b1;
    settle();
  endtask

  task automatic resolve(input logic taken, input logic [31:0] target);
    resolveValid  = 1'b1;
    resolveTaken  = taken;
    resolveTarget = target;
  endtask

  task automatic noResolve();
    resolveValid  = 1'b0;
    resolveTaken  = 1'b0;
    resolveTarget = 32'd0;
  endtask

  initial begin
    clearBtb();
    reset         = 1'b0;
    stall         = 1'b0;
    resolveValid  = 1'b0;
    resolveTaken  = 1'b0;
    resolveTarget = 32'd0;
    #3;
    checkEq("rst_fetchPc", fetchPc, 32'd0);
    checkEq("rst_btbPc", btbPc, 32'd0);
    checkEq("rst_fetchValid", fetchValid, 0);
    checkEq("rst_resolveReady", resolveReady, 0);
    checkEq("rst_redirect", redirect, 0);
    checkEq("rst_btaWrite", btaWrite, 0);
    checkEq("rst_wpbe", writePredBuffEn, 0);
    checkEq("rst_actualPredict", actualPredict, 0);
    checkEq("rst_bta", bta, 0);
    checkEq("rst_resolveErr", resolveErr, 0);

    // Sequential fetch until the queue fills, then one correct resolve.
    doReset();
    for (int i = 0; i < 4; i++) begin
      checkEq($sformatf("seq_fetchPc%0d", i), fetchPc, i);
      checkEq($sformatf("seq_valid%0d", i), fetchValid, 1);
      checkEq($sformatf("seq_btbPc%0d", i), btbPc, i);
      tick();
    end
    checkEq("full_fetchPc", fetchPc, 32'd4);
    checkEq("full_valid", fetchValid, 0);
    tick();
    checkEq("full_hold", fetchPc, 32'd4);
    resolve(1'b0, 32'd0);
    settle();
    checkEq("full_resReady", resolveReady, 1);
    checkEq("full_noRedirect", redirect, 0);
    tick();
    noResolve();
    settle();
    checkEq("full_upd_wpbe", writePredBuffEn, 1);
    checkEq("full_upd_btbPc", btbPc, 32'd0);
    checkEq("full_upd_btaWrite", btaWrite, 0);
    checkEq("full_upd_ready", resolveReady, 0);
    checkEq("full_upd_valid", fetchValid, 0);
    tick();
    checkEq("full_resume_valid", fetchValid, 1);
    checkEq("full_resume_wpbe", writePredBuffEn, 0);
    tick();
    checkEq("full_resume_pc", fetchPc, 32'd5);

    // Predicted-taken redirect from BTB entry 1.
    clearBtb();
    btbTgt[1] = 32'd7;
    btbCnt[1] = 2'b00;
    doReset();
    tick();
    checkEq("tk_fetchPc1", fetchPc, 32'd1);
    tick();
    stall = 1'b1;
    settle();
    checkEq("tk_fetchPc7", fetchPc, 32'd7);
    checkEq("tk_stall_valid", fetchValid, 0);
    resolve(1'b0, 32'd0);
    settle();
    checkEq("tk_r1_redirect", redirect, 0);
    tick();
    noResolve();
    settle();
    checkEq("tk_r1_btbPc", btbPc, 32'd0);
    tick();
    resolve(1'b1, 32'd7);
    settle();
    checkEq("tk_r2_ready", resolveReady, 1);
    checkEq("tk_r2_redirect", redirect, 0);
    tick();
    noResolve();
    settle();
    checkEq("tk_upd_btbPc", btbPc, 32'd1);
    checkEq("tk_upd_btaWrite", btaWrite, 1);
    checkEq("tk_upd_bta", bta, 32'd7);
    checkEq("tk_upd_actual", actualPredict, 1);
    checkEq("tk_upd_pc", fetchPc, 32'd7);

    // Head {3,taken,11} resolves not-taken.
    clearBtb();
    btbTgt[0] = 32'd3;
    btbCnt[0] = 2'b00;
    btbTgt[3] = 32'd11;
    btbCnt[3] = 2'b01;
    doReset();
    tick();
    checkEq("mp_fetchPc3", fetchPc, 32'd3);
    tick();
    stall = 1'b1;
    settle();
    checkEq("mp_fetchPc11", fetchPc, 32'd11);
    resolve(1'b1, 32'd3);
    settle();
    checkEq("mp_r1_redirect", redirect, 0);
    tick();
    noResolve();
    tick();
    resolve(1'b0, 32'd0);
    settle();
    checkEq("mp_redirect", redirect, 1);
    checkEq("mp_valid", fetchValid, 0);
    tick();
    noResolve();
    stall = 1'b0;
    settle();
    checkEq("mp_n1_redirect", redirect, 0);
    checkEq("mp_n1_empty", resolveReady, 0);
    checkEq("mp_n1_btbPc", btbPc, 32'd3);
    checkEq("mp_n1_wpbe", writePredBuffEn, 1);
    checkEq("mp_n1_actual", actualPredict, 0);
    checkEq("mp_n1_btaWrite", btaWrite, 0);
    checkEq("mp_n1_valid", fetchValid, 0);
    checkEq("mp_n1_pc", fetchPc, 32'd4);
    tick();
    checkEq("mp_n2_pc", fetchPc, 32'd4);
    checkEq("mp_n2_valid", fetchValid, 1);

    // Head {2,not-taken} resolves taken to 9.
    clearBtb();
    btbTgt[0] = 32'd2;
    btbCnt[0] = 2'b00;
    doReset();
    tick();
    checkEq("nt_fetchPc2", fetchPc, 32'd2);
    tick();
    stall = 1'b1;
    settle();
    checkEq("nt_fetchPc3", fetchPc, 32'd3);
    resolve(1'b1, 32'd2);
    tick();
    noResolve();
    tick();
    resolve(1'b1, 32'd9);
    settle();
    checkEq("nt_redirect", redirect, 1);
    tick();
    noResolve();
    stall = 1'b0;
    settle();
    checkEq("nt_upd_bta", bta, 32'd9);
    checkEq("nt_upd_btaWrite", btaWrite, 1);
    checkEq("nt_upd_btbPc", btbPc, 32'd2);
    checkEq("nt_upd_actual", actualPredict, 1);
    checkEq("nt_upd_pc", fetchPc, 32'd9);
    tick();
    checkEq("nt_fetch9_valid", fetchValid, 1);
    checkEq("nt_fetch9_pc", fetchPc, 32'd9);
    tick();
    checkEq("nt_fetch10_pc", fetchPc, 32'd10);

    // Resolve on an empty queue, then reset in the middle of an update.
    clearBtb();
    btbTgt[0] = 32'd5;
    btbCnt[0] = 2'b00;
    doReset();
    stall = 1'b1;
    resolve(1'b1, 32'd5);
    settle();
    checkEq("err_ready", resolveReady, 0);
    checkEq("err_redirect", redirect, 0);
    tick();
    noResolve();
    settle();
    checkEq("err_wpbe", writePredBuffEn, 0);
    checkEq("err_btaWrite", btaWrite, 0);
    checkEq("err_flag", resolveErr, 1);
    stall = 1'b0;
    tick();
    stall = 1'b1;
    settle();
    checkEq("err_flag_sticky", resolveErr, 1);
    checkEq("rm_fetchPc5", fetchPc, 32'd5);
    resolve(1'b1, 32'd5);
    tick();
    noResolve();
    settle();
    checkEq("rm_upd_btaWrite", btaWrite, 1);
    reset = 1'b0;
    #1;
    checkEq("rm_btaWrite", btaWrite, 0);
    checkEq("rm_wpbe", writePredBuffEn, 0);
    checkEq("rm_bta", bta, 32'd0);
    checkEq("rm_fetchPc", fetchPc, 32'd0);
    checkEq("rm_btbPc", btbPc, 32'd0);
    checkEq("rm_resolveErr", resolveErr, 0);
    tick();
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage program-counter generator that sits directly upstream of the BTB/prediction-buffer block. It drives the BTB lookup PC and consumes the returned target (`btaBuffOp`) and 2-bit counter (`predBuffOp`) to choose the next fetch PC. It records every prediction in an in-flight queue and compares the queue head against branch resolution from execute. It then issues the redirect and BTB/prediction-buffer update strobes.

## Interface
- `RESET_PC`, 32'd0: fetch PC after reset.
- `DEPTH`, 4: in-flight prediction queue entries, power of two, at least 2.
- `clk` in 1: single clock. All state changes on posedge.
- `reset` in 1: asynchronous, active-low. When low, all state clears immediately.
- `stall` in 1: downstream fetch stall.
- `btbPc` out 32: PC presented to the BTB `pc` port.
- `btaBuffOp` in 32: BTB target for `btbPc`. 32'd0 means no entry.
- `predBuffOp` in 2: counter for `btbPc`.
- `fetchPc` out 32: current fetch PC.
- `fetchValid` out 1: fetch accepted this cycle.
- `resolveValid` in 1: execute presents the oldest branch outcome.
- `resolveReady` out 1: block accepts the resolution this cycle.
- `resolveTaken` in 1: actual direction.
- `resolveTarget` in 32: actual target.
- `redirect` out 1: one-cycle pulse on mispredict.
- `btaWrite` out 1: BTB target write strobe.
- `bta` out 32: BTB write data.
- `actualPredict` out 1: prediction-buffer outcome input.
- `writePredBuffEn` out 1: prediction-buffer write enable.
- `resolveErr` out 1: sticky flag, set on resolve with an empty queue.

## Operation
- PC is a word address. The sequential next PC is `fetchPc+1`, and the BTB index is `pc[1:0]`.
- Counter decode:
  - 00 = strong taken, 01 = weak taken (both predict taken).
  - 10 = strong not-taken, 11 = weak not-taken (both predict not-taken).
- `predTaken = !predBuffOp[1] && btaBuffOp != 0`.
- `predNext = predTaken ? btaBuffOp : fetchPc+1`.
- `fetchFire = !stall && !full && !updActive && !mispredict`.
  - On fire: push {fetchPc, predTaken, btaBuffOp}, then `fetchPc <= predNext`.
  - Otherwise `fetchPc` holds.
- `resolveReady = !empty && !updActive`. A resolve fires when `resolveValid && resolveReady`.
- On a resolve fire, the head is popped.
- `mispredict` on a resolve fire is true when either:
  - head.predTaken ≠ `resolveTaken`, or
  - `resolveTaken` and head target ≠ `resolveTarget`.
- On mispredict:
  - `fetchPc <= resolveTaken ? resolveTarget : head.pc+1`.
  - The queue is flushed to empty.
  - `redirect` = 1 for that cycle.
  - No push occurs.
- Every resolve fire arms the update stage for the next cycle (`updActive` = 1):
  - `btbPc` = resolved PC.
  - `writePredBuffEn` = 1.
  - `actualPredict = resolveTaken`.
  - `btaWrite = resolveTaken`.
  - `bta = resolveTarget`.
- When `updActive` = 0: `btbPc = fetchPc`, and all update strobes are 0.
- `resolveValid` with an empty queue is ignored and sets `resolveErr`. `resolveErr` clears only on reset.
- Queue uses a wrap-around read/write pointer with a count.
  - A push and a non-mispredict pop in the same cycle keep the count.
  - A push when full is impossible, because full blocks fire.

## Timing
- Reset values:
  - `fetchPc`/`btbPc` = `RESET_PC`.
  - Queue empty, `resolveReady` = 0.
  - `fetchValid`, `redirect`, `btaWrite`, `writePredBuffEn`, `actualPredict` = 0.
  - `bta` = 0, `resolveErr` = 0.
- Lookup is combinational within one cycle: `btbPc` → `btaBuffOp`/`predBuffOp` → `predNext`.
- Update lasts exactly one full cycle with `btbPc` stable. This satisfies the prediction buffer (compute on posedge, write on negedge) and the BTB negedge write.
- Mispredict latency:
  - Resolve in cycle N.
  - Corrected `fetchPc` visible in N+1, which is the update cycle, so no fetch occurs.
  - First fetch from the corrected PC in N+2.
- Back-to-back resolves: `resolveReady` = 0 in the update cycle, so the second resolve is accepted one cycle later.
- Reset asserted mid-operation drops the queue, update stage and strobes immediately, with no partial BTB write.

## Structure
- Shared package: counter encodings (`PRED_ST`=2'b00, `PRED_WT`=2'b01, `PRED_SN`=2'b10, `PRED_WN`=2'b11) and the `predTaken` decode function.
- Sub-module `pred_fifo`:
  - Parameterized `DEPTH`, 65-bit entries.
  - Ports: push, pop, flush, full, empty, head.
  - Asynchronous active-low reset.
- The top level holds the PC register, mispredict compare, update stage and `btbPc` mux.

## Test plan
- Reset with `RESET_PC`=0 and BTB all zero, 4 cycles unstalled → `fetchPc` 0,1,2,3. `fetchValid`=1 each cycle and `btbPc`=`fetchPc`.
- Entry 1 holds `bta`=7 and pred=00 at `fetchPc`=1 → next `fetchPc`=7. Pushed entry is {1,1,7}.
- Queue full (4 pushes, no resolve) → `fetchPc` holds and `fetchValid`=0. One correct resolve → `resolveReady`=1, update cycle with `writePredBuffEn`=1, then fetch resumes.
- Head {3,taken,11}, resolve not-taken → `redirect` pulse, queue empty. Next cycle: `btbPc`=3, `actualPredict`=0, `btaWrite`=0. The cycle after: `fetchPc`=4.
- Head {2,not-taken}, resolve taken with target 9 → update `bta`=9, `btaWrite`=1, then fetch from 9.
- `resolveValid` with an empty queue → no strobes, `resolveErr`=1. `reset` low mid-update → strobes 0 immediately, `fetchPc`=`RESET_PC`.
